// File: rtl/dac_seq_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : dac_seq_arbiter_if
// Purpose  : Request/grant/DAC-code bundle between requesters and the arbiter.
// Revision : 1.0
// ============================================================================
interface dac_seq_arbiter_if;
    logic [1:0] req;
    logic [2:0] code0;
    logic [2:0] code1;
    logic [1:0] gnt;
    logic [1:0] done;
    logic       busy;
    logic [3:0] b;
    logic [2:0] level;

    modport master (
        output req, code0, code1,
        input  gnt, done, busy, b, level
    );

    modport slave (
        input  req, code0, code1,
        output gnt, done, busy, b, level
    );
endinterface

`default_nettype wire

// File: rtl/dac_seq_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dac_seq_arbiter
// Purpose  : Round-robin sharing of a 4-bit thermometer DAC between two
//            requesters; optional one-step-per-cycle ramp under DAC_RAMP_EN.
// Revision : 1.0
// ============================================================================
module dac_seq_arbiter #(
    parameter int SETTLE_CYCLES = 4   // legal 1..15
) (
    input  wire logic        clk,
    input  wire logic        rst,
    dac_seq_arbiter_if.slave bus
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_RAMP   = 2'd1;
    localparam logic [1:0] c_SETTLE = 2'd2;
    localparam logic [1:0] c_DONE   = 2'd3;

    localparam logic [3:0] c_SETTLE_LOAD = 4'(SETTLE_CYCLES);

    function automatic logic [3:0] therm(input logic [2:0] lvl);
        logic [3:0] r;
        case (lvl)
            3'd0:    r = 4'b0000;
            3'd1:    r = 4'b0001;
            3'd2:    r = 4'b0011;
            3'd3:    r = 4'b0111;
            default: r = 4'b1111;
        endcase
        return r;
    endfunction

    function automatic logic [2:0] clamp(input logic [2:0] c);
        return (c > 3'd4) ? 3'd4 : c;
    endfunction

    logic [1:0] state_q,   state_d;
    logic [2:0] level_q,   level_d;
    logic [3:0] cnt_q,     cnt_d;
    logic [1:0] gnt_q,     gnt_d;
    logic [1:0] done_q,    done_d;
    logic       busy_q,    busy_d;
    logic [3:0] b_q,       b_d;
    logic       rr_last_q, rr_last_d;
`ifdef DAC_RAMP_EN
    logic [2:0] target_q,  target_d;
`endif

    logic       w_win;
    logic [2:0] w_tgt;

    // On a tie the requester that did not win last time is served.
    always_comb begin
        case (bus.req)
            2'b01:   w_win = 1'b0;
            2'b10:   w_win = 1'b1;
            default: w_win = ~rr_last_q;
        endcase
    end

    assign w_tgt = w_win ? clamp(bus.code1) : clamp(bus.code0);

    always_comb begin
        state_d   = state_q;
        level_d   = level_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt_q;
        rr_last_d = rr_last_q;
`ifdef DAC_RAMP_EN
        target_d  = target_q;
`endif
        case (state_q)
            c_IDLE: begin
                gnt_d = 2'b00;
                if (bus.req != 2'b00) begin
                    gnt_d     = w_win ? 2'b10 : 2'b01;
                    rr_last_d = w_win;
`ifdef DAC_RAMP_EN
                    target_d  = w_tgt;
                    state_d   = c_RAMP;
`else
                    level_d   = w_tgt;
                    cnt_d     = c_SETTLE_LOAD;
                    state_d   = c_SETTLE;
`endif
                end
            end
            c_RAMP: begin
`ifdef DAC_RAMP_EN
                if (level_q < target_q) begin
                    level_d = level_q + 3'd1;
                end else if (level_q > target_q) begin
                    level_d = level_q - 3'd1;
                end else begin
                    cnt_d   = c_SETTLE_LOAD;
                    state_d = c_SETTLE;
                end
`else
                // Unreachable without ramp support; recover to IDLE.
                gnt_d   = 2'b00;
                state_d = c_IDLE;
`endif
            end
            c_SETTLE: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = c_DONE;
                end
            end
            default: begin
                gnt_d   = 2'b00;
                state_d = c_IDLE;
            end
        endcase
    end

    // Outputs are derived from next-state values so every port is a flop.
    assign done_d = (state_d == c_DONE) ? gnt_d : 2'b00;
    assign busy_d = (state_d != c_IDLE);
    assign b_d    = therm(level_d);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= c_IDLE;
            level_q   <= 3'd0;
            cnt_q     <= 4'd0;
            gnt_q     <= 2'b00;
            done_q    <= 2'b00;
            busy_q    <= 1'b0;
            b_q       <= 4'b0000;
            rr_last_q <= 1'b1;
`ifdef DAC_RAMP_EN
            target_q  <= 3'd0;
`endif
        end else begin
            state_q   <= state_d;
            level_q   <= level_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            b_q       <= b_d;
            rr_last_q <= rr_last_d;
`ifdef DAC_RAMP_EN
            target_q  <= target_d;
`endif
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.done  = done_q;
    assign bus.busy  = busy_q;
    assign bus.b     = b_q;
    assign bus.level = level_q;

endmodule

`default_nettype wire
